// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch stage: instruction field constants
// and the fetch FSM state type.
package fetch_unit_pkg;

  // Instruction field positions, counted down from the MSB of the instruction word.
  localparam int unsigned TYPE_W = 2;
  localparam int unsigned OP_W   = 2;

  // Instruction type / opcode encodings relevant to fetch.
  localparam logic [TYPE_W-1:0] TYPE_CTRL = 2'b11;
  localparam logic [OP_W-1:0]   OP_END    = 2'b11;

  typedef enum logic [1:0] {
    StStart,
    StRun,
    StHalt
  } fetch_state_t;

  // True when the top nibble {type, op} decodes as CTRL/END.
  function automatic logic is_end_instr(input logic [TYPE_W+OP_W-1:0] top_nibble);
    return top_nibble == {TYPE_CTRL, OP_END};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-fetch address selection: priority mux driving the instruction memory address.
module pc_next_sel
  import fetch_unit_pkg::*;
#(
  parameter int unsigned I        = 32,
  parameter logic [I-1:0] RESET_PC = '0
) (
  input  logic         reset_i,
  input  fetch_state_t state_i,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  logic [I-1:0] branch_target_i,
  input  logic [I-1:0] pcf_i,
  output logic [I-1:0] imem_addr_o
);

  logic [I-1:0] target_aligned;

  // Branch targets are always word aligned; low two bits are dropped.
  assign target_aligned = branch_target_i & ~(I'(3));

  // Priority: reset/START > HALT > redirect > stall > sequential.
  always_comb begin
    imem_addr_o = pcf_i + I'(4);
    if (reset_i || (state_i == StStart)) begin
      imem_addr_o = RESET_PC;
    end else if (state_i == StHalt) begin
      imem_addr_o = pcf_i;
    end else if (branch_taken_i) begin
      imem_addr_o = target_aligned;
    end else if (stall_i) begin
      imem_addr_o = pcf_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction memory,
// and handles stall, branch redirect, halt on END and delivered-instruction counting.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned I        = 32,
  parameter logic [I-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         StallF,
  input  logic         BranchTakenE,
  input  logic [I-1:0] BranchTargetE,
  output logic [I-1:0] ImemAddr,
  input  logic [I-1:0] ImemData,
  output logic [I-1:0] InstrF,
  output logic [I-1:0] PCF,
  output logic         ValidF,
  output logic         FlushD,
  output logic         HaltedF,
  output logic [31:0]  FetchCount
);

  fetch_state_t state_q, state_d;
  logic [I-1:0] pcf_q, pcf_d;
  logic         valid_q, valid_d;
  logic [31:0]  count_q, count_d;

  logic deliver;
  logic halt_now;

  pc_next_sel #(
    .I        (I),
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .reset_i         (reset),
    .state_i         (state_q),
    .stall_i         (StallF),
    .branch_taken_i  (BranchTakenE),
    .branch_target_i (BranchTargetE),
    .pcf_i           (pcf_q),
    .imem_addr_o     (ImemAddr)
  );

  // An instruction is handed downstream when valid, not held and not on the wrong path.
  assign deliver  = valid_q && !StallF && !BranchTakenE;
  assign halt_now = (state_q == StRun) && deliver && is_end_instr(ImemData[I-1 -: 4]);

  // FSM next state and the per-state valid / PC update.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pcf_d   = ImemAddr;
    unique case (state_q)
      StStart: begin
        state_d = StRun;
        valid_d = 1'b1;
      end
      StRun: begin
        if (halt_now) begin
          state_d = StHalt;
          valid_d = 1'b0;
          // Freeze on the END address rather than following the speculative PC+4.
          pcf_d   = pcf_q;
        end else begin
          valid_d = 1'b1;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
        pcf_d   = pcf_q;
      end
      default: begin
        state_d = StStart;
        valid_d = 1'b0;
      end
    endcase
  end

  // Saturating count of delivered instructions.
  always_comb begin
    count_d = count_q;
    if (deliver && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StStart;
      pcf_q   <= RESET_PC;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign InstrF     = ImemData;
  assign PCF        = pcf_q;
  assign ValidF     = valid_q;
  assign FlushD     = BranchTakenE;
  assign HaltedF    = (state_q == StHalt);
  assign FetchCount = count_q;

endmodule
